// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline control register bank.
//   REG_W      : register-ID width of the 4-bit register file
//   NOP_INSTR  : encoding loaded into IF/ID on reset or branch clear
//   ctrl_t     : ID/EX control/ID bundle
//   BUBBLE     : all-zero ctrl_t, never a forwarding source
//   mw_ctrl_t  : reduced bundle carried through EX/MEM and MEM/WB
//   to_mw()    : drops source IDs that are dead after EX
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int          REG_W     = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] wreg;
        logic             regwrite;
        logic             memtoreg;
        logic             valid;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Source IDs are only consulted by the hazard unit in EX, so the later
    // stages carry just the destination side.
    typedef struct packed {
        logic [REG_W-1:0] wreg;
        logic             regwrite;
        logic             memtoreg;
        logic             valid;
    } mw_ctrl_t;

    function automatic mw_ctrl_t to_mw(input ctrl_t c);
        mw_ctrl_t m;
        m.wreg     = c.wreg;
        m.regwrite = c.regwrite;
        m.memtoreg = c.memtoreg;
        m.valid    = c.valid;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs_if
// Bundle between the hazard unit / fetch-decode datapath (master) and the
// pipeline control register bank (slave).
//   Hazard controls : StallF, StallD, FlushE (all inverted sense: 1 = advance
//                     / load normally, 0 = hold / bubble)
//   Decode inputs   : InstrF, PCSrcD, PCBranchD, RsD, RtD, WriteRegD,
//                     RegWriteD, MemtoRegD, CntClr
//   Stage outputs   : PCF, InstrD, PCPlus1D, Valid{D,E,M,W}, RsE, RtE,
//                     WriteReg{E,M,W}, RegWrite{E,M,W}, MemtoReg{E,M,W}
//   Perf counters   : StallCnt, FlushCnt
// -----------------------------------------------------------------------------
interface pipe_ctrl_regs_if #(
    parameter int PC_W  = 16,
    parameter int REG_W = pipe_pkg::REG_W,
    parameter int CNT_W = 16
);
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic [31:0]      InstrF;
    logic             PCSrcD;
    logic [PC_W-1:0]  PCBranchD;
    logic [REG_W-1:0] RsD;
    logic [REG_W-1:0] RtD;
    logic [REG_W-1:0] WriteRegD;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic             CntClr;

    logic [PC_W-1:0]  PCF;
    logic [31:0]      InstrD;
    logic [PC_W-1:0]  PCPlus1D;
    logic             ValidD;
    logic             ValidE;
    logic             ValidM;
    logic             ValidW;
    logic [REG_W-1:0] RsE;
    logic [REG_W-1:0] RtE;
    logic [REG_W-1:0] WriteRegE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic [REG_W-1:0] WriteRegM;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic [REG_W-1:0] WriteRegW;
    logic             RegWriteW;
    logic             MemtoRegW;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;

    modport master (
        output StallF, StallD, FlushE, InstrF, PCSrcD, PCBranchD,
               RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, CntClr,
        input  PCF, InstrD, PCPlus1D, ValidD, ValidE, ValidM, ValidW,
               RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
               WriteRegM, RegWriteM, MemtoRegM,
               WriteRegW, RegWriteW, MemtoRegW, StallCnt, FlushCnt
    );

    modport slave (
        input  StallF, StallD, FlushE, InstrF, PCSrcD, PCBranchD,
               RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, CntClr,
        output PCF, InstrD, PCPlus1D, ValidD, ValidE, ValidM, ValidW,
               RsE, RtE, WriteRegE, RegWriteE, MemtoRegE,
               WriteRegM, RegWriteM, MemtoRegM,
               WriteRegW, RegWriteW, MemtoRegW, StallCnt, FlushCnt
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline register with enable and synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset to RST_VAL
//   en         : 1 = capture on this edge, 0 = hold
//   clr        : when enabled, load RST_VAL instead of d (bubble / squash)
//   d, q       : W-bit data in / out
// Hold has priority over clear, so a stalled stage is never squashed.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= clr ? RST_VAL : d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_regs
// PC, IF/ID, ID/EX, EX/MEM, MEM/WB control registers of the 5-stage core plus
// saturating stall / branch-flush performance counters.
//   clk   : core clock
//   rst_n : asynchronous active-low reset; invalidates every stage at once
//   bus   : pipe_ctrl_regs_if slave (hazard controls in, stage IDs/control out)
// -----------------------------------------------------------------------------
module pipe_ctrl_regs
    import pipe_pkg::ctrl_t, pipe_pkg::mw_ctrl_t, pipe_pkg::BUBBLE,
           pipe_pkg::NOP_INSTR, pipe_pkg::to_mw;
#(
    parameter int              PC_W     = 16,
    parameter int              REG_W    = 4,   // must equal pipe_pkg::REG_W
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_ctrl_regs_if.slave      bus
);

    localparam int              IFID_W  = 32 + PC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ---------------------------------------------------------------- PC
    logic [PC_W-1:0] pc_f;
    logic [PC_W-1:0] pc_plus1;

    assign pc_plus1 = pc_f + 1'b1;   // wraps mod 2^PC_W

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f <= RESET_PC;
        end else if (bus.StallF) begin
            pc_f <= bus.PCSrcD ? bus.PCBranchD : pc_plus1;
        end
    end

    // ---------------------------------------------------------------- IF/ID
    // A taken branch squashes the instruction fetched behind it, but only if
    // IF/ID is allowed to move this cycle.
    logic [IFID_W-1:0] if_id_d;
    logic [IFID_W-1:0] if_id_q;
    logic [31:0]       instr_d;
    logic [PC_W-1:0]   pcp1_d;
    logic              valid_d;

    assign if_id_d = {bus.InstrF, pc_plus1, 1'b1};

    pipe_stage_reg #(
        .W       (IFID_W),
        .RST_VAL ({NOP_INSTR, {PC_W{1'b0}}, 1'b0})
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.StallD),
        .clr   (bus.PCSrcD),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign {instr_d, pcp1_d, valid_d} = if_id_q;

    // ---------------------------------------------------------------- ID/EX
    logic [REG_W-1:0] rs_d;
    logic [REG_W-1:0] rt_d;
    logic [REG_W-1:0] wreg_d;
    ctrl_t            id_ex_d;
    ctrl_t            id_ex_q;

    assign rs_d   = bus.RsD;
    assign rt_d   = bus.RtD;
    assign wreg_d = bus.WriteRegD;

    // NOTE: every field is assigned before use, so no latch can be inferred.
    always_comb begin
        id_ex_d          = BUBBLE;
        id_ex_d.rs       = rs_d;
        id_ex_d.rt       = rt_d;
        id_ex_d.wreg     = wreg_d;
        // A squashed IF/ID slot must never write the register file.
        id_ex_d.regwrite = bus.RegWriteD & valid_d;
        id_ex_d.memtoreg = bus.MemtoRegD & valid_d;
        id_ex_d.valid    = valid_d;
    end

    pipe_stage_reg #(
        .W       ($bits(ctrl_t)),
        .RST_VAL (BUBBLE)
    ) u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (~bus.FlushE),   // inverted sense: 0 inserts a bubble
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    // ---------------------------------------------------------------- EX/MEM, MEM/WB
    mw_ctrl_t ex_mem_q;
    mw_ctrl_t mem_wb_q;

    pipe_stage_reg #(
        .W       ($bits(mw_ctrl_t)),
        .RST_VAL ('0)
    ) u_ex_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (to_mw(id_ex_q)),
        .q     (ex_mem_q)
    );

    pipe_stage_reg #(
        .W       ($bits(mw_ctrl_t)),
        .RST_VAL ('0)
    ) u_mem_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .d     (ex_mem_q),
        .q     (mem_wb_q)
    );

    // ---------------------------------------------------------------- counters
    // Clear wins over increment; both stick at all-ones instead of wrapping.
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (bus.CntClr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.StallD && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (bus.StallD && bus.PCSrcD && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.PCF       = pc_f;
    assign bus.InstrD    = instr_d;
    assign bus.PCPlus1D  = pcp1_d;
    assign bus.ValidD    = valid_d;

    assign bus.RsE       = id_ex_q.rs;
    assign bus.RtE       = id_ex_q.rt;
    assign bus.WriteRegE = id_ex_q.wreg;
    assign bus.RegWriteE = id_ex_q.regwrite;
    assign bus.MemtoRegE = id_ex_q.memtoreg;
    assign bus.ValidE    = id_ex_q.valid;

    assign bus.WriteRegM = ex_mem_q.wreg;
    assign bus.RegWriteM = ex_mem_q.regwrite;
    assign bus.MemtoRegM = ex_mem_q.memtoreg;
    assign bus.ValidM    = ex_mem_q.valid;

    assign bus.WriteRegW = mem_wb_q.wreg;
    assign bus.RegWriteW = mem_wb_q.regwrite;
    assign bus.MemtoRegW = mem_wb_q.memtoreg;
    assign bus.ValidW    = mem_wb_q.valid;

    assign bus.StallCnt  = stall_cnt;
    assign bus.FlushCnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_regs
// Directed stimulus for pipe_ctrl_regs. A behavioural model (PC value, IF/ID
// record, a three-deep E/M/W shift array, integer counters) is compared with
// every DUT output on each falling clock edge; directed literal checks taken
// one time unit after rising edges pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_regs;

    localparam int              PC_W     = 16;
    localparam int              REG_W    = 4;
    localparam int              CNT_W    = 16;
    localparam logic [PC_W-1:0] RESET_PC = '0;
    localparam int              PC_MOD   = 1 << PC_W;
    localparam int              CNT_MAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_regs_if #(.PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_ctrl_regs #(
        .PC_W     (PC_W),
        .REG_W    (REG_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ model
    typedef struct {
        int rs;
        int rt;
        int wreg;
        bit rw;
        bit m2r;
        bit valid;
    } st_t;

    int  m_pc      = 0;
    int  m_instr_d = 0;
    int  m_pcp1_d  = 0;
    bit  m_valid_d = 0;
    st_t m_st[3];          // [0]=E, [1]=M, [2]=W
    int  m_stall   = 0;
    int  m_flush   = 0;

    task automatic model_reset();
        m_pc      = int'(RESET_PC);
        m_instr_d = 0;
        m_pcp1_d  = 0;
        m_valid_d = 0;
        for (int i = 0; i < 3; i++) m_st[i] = '{0, 0, 0, 0, 0, 0};
        m_stall   = 0;
        m_flush   = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int  old_pc;
            bit  old_valid;
            st_t e;
            old_pc    = m_pc;
            old_valid = m_valid_d;

            if (bus.StallF)
                m_pc = bus.PCSrcD ? int'(bus.PCBranchD) : (old_pc + 1) % PC_MOD;

            if (bus.StallD) begin
                if (bus.PCSrcD) begin
                    m_instr_d = 0; m_pcp1_d = 0; m_valid_d = 0;
                end else begin
                    m_instr_d = int'(bus.InstrF);
                    m_pcp1_d  = (old_pc + 1) % PC_MOD;
                    m_valid_d = 1;
                end
            end

            e = '{0, 0, 0, 0, 0, 0};
            if (bus.FlushE) begin
                e.rs    = int'(bus.RsD);
                e.rt    = int'(bus.RtD);
                e.wreg  = int'(bus.WriteRegD);
                e.rw    = bus.RegWriteD && old_valid;
                e.m2r   = bus.MemtoRegD && old_valid;
                e.valid = old_valid;
            end
            m_st[2] = m_st[1];
            m_st[1] = m_st[0];
            m_st[0] = e;

            if (bus.CntClr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if (!bus.StallD && m_stall < CNT_MAX) m_stall++;
                if (bus.StallD && bus.PCSrcD && m_flush < CNT_MAX) m_flush++;
            end
        end
    end

    // ------------------------------------------------------------ compare
    always @(negedge clk) begin
        check("PCF",       bus.PCF,       m_pc);
        check("InstrD",    bus.InstrD,    m_instr_d);
        check("PCPlus1D",  bus.PCPlus1D,  m_pcp1_d);
        check("ValidD",    bus.ValidD,    m_valid_d);
        check("RsE",       bus.RsE,       m_st[0].rs);
        check("RtE",       bus.RtE,       m_st[0].rt);
        check("WriteRegE", bus.WriteRegE, m_st[0].wreg);
        check("RegWriteE", bus.RegWriteE, m_st[0].rw);
        check("MemtoRegE", bus.MemtoRegE, m_st[0].m2r);
        check("ValidE",    bus.ValidE,    m_st[0].valid);
        check("WriteRegM", bus.WriteRegM, m_st[1].wreg);
        check("RegWriteM", bus.RegWriteM, m_st[1].rw);
        check("MemtoRegM", bus.MemtoRegM, m_st[1].m2r);
        check("ValidM",    bus.ValidM,    m_st[1].valid);
        check("WriteRegW", bus.WriteRegW, m_st[2].wreg);
        check("RegWriteW", bus.RegWriteW, m_st[2].rw);
        check("MemtoRegW", bus.MemtoRegW, m_st[2].m2r);
        check("ValidW",    bus.ValidW,    m_st[2].valid);
        check("StallCnt",  bus.StallCnt,  m_stall);
        check("FlushCnt",  bus.FlushCnt,  m_flush);
    end

    // ------------------------------------------------------------ stimulus
    // Each tick presents a fresh instruction word, lets one rising edge pass,
    // and returns 1 time unit later with outputs settled.
    task automatic tick();
        tick_no++;
        bus.InstrF = 32'h1000_0000 + 32'(tick_no);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input bit sf, input bit sd, input bit fe, input bit br);
        bus.StallF = sf;
        bus.StallD = sd;
        bus.FlushE = fe;
        bus.PCSrcD = br;
    endtask

    initial begin
        set_ctl(0, 0, 0, 0);
        bus.InstrF    = '0;
        bus.PCBranchD = '0;
        bus.RsD       = 4'd1;
        bus.RtD       = 4'd2;
        bus.WriteRegD = '0;
        bus.RegWriteD = 0;
        bus.MemtoRegD = 0;
        bus.CntClr    = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_PCF",      bus.PCF, 0);
        check("rst_InstrD",   bus.InstrD, 0);
        check("rst_ValidD",   bus.ValidD, 0);
        check("rst_StallCnt", bus.StallCnt, 0);
        set_ctl(1, 1, 1, 0);
        rst_n = 1'b1;

        // Free-running fetch: PCF 1,2,3.
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("run_PCF", bus.PCF, i);
            check("run_ValidD", bus.ValidD, 1);
        end
        check("run_PCPlus1D", bus.PCPlus1D, 3);

        // Destination 5 travels E -> M -> W.
        bus.WriteRegD = 4'd5;
        bus.RegWriteD = 1;
        tick();
        check("ld_WriteRegE", bus.WriteRegE, 5);
        check("ld_RegWriteE", bus.RegWriteE, 1);
        bus.WriteRegD = 4'd0;
        bus.RegWriteD = 0;
        tick();
        check("ld_WriteRegM", bus.WriteRegM, 5);
        tick();
        check("ld_WriteRegW", bus.WriteRegW, 5);
        check("ld_RegWriteW", bus.RegWriteW, 1);
        check("ld_PCF", bus.PCF, 6);

        // Load-use stall: PC and IF/ID hold, E gets a bubble.
        bus.WriteRegD = 4'd7;
        bus.RegWriteD = 1;
        set_ctl(0, 0, 0, 0);
        tick();
        check("lu_PCF", bus.PCF, 6);
        check("lu_InstrD", bus.InstrD, 32'h1000_0006);
        check("lu_RegWriteE", bus.RegWriteE, 0);
        check("lu_WriteRegE", bus.WriteRegE, 0);
        check("lu_StallCnt", bus.StallCnt, 1);

        // Taken branch clears IF/ID.
        bus.PCBranchD = 16'h0040;
        set_ctl(1, 1, 1, 1);
        tick();
        check("br_PCF", bus.PCF, 16'h0040);
        check("br_InstrD", bus.InstrD, 0);
        check("br_ValidD", bus.ValidD, 0);
        check("br_PCPlus1D", bus.PCPlus1D, 0);
        check("br_FlushCnt", bus.FlushCnt, 1);

        // Branch under a D stall: hold wins, no flush counted; the invalid
        // IF/ID slot must not produce a write in E.
        set_ctl(0, 0, 1, 1);
        tick();
        check("brh_ValidD", bus.ValidD, 0);
        check("brh_InstrD", bus.InstrD, 0);
        check("brh_FlushCnt", bus.FlushCnt, 1);
        check("brh_StallCnt", bus.StallCnt, 2);
        check("brh_RegWriteE", bus.RegWriteE, 0);
        check("brh_ValidE", bus.ValidE, 0);

        // Drive StallCnt to 0xFFFE, then saturate.
        set_ctl(0, 0, 1, 0);
        repeat (16'hFFFE - 2) tick();
        check("sat_StallCnt_fffe", bus.StallCnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_StallCnt", bus.StallCnt, 16'hFFFF);
        end

        // Clear beats increment.
        bus.CntClr = 1;
        tick();
        check("clr_StallCnt", bus.StallCnt, 0);
        check("clr_FlushCnt", bus.FlushCnt, 0);
        bus.CntClr = 0;

        // Refill the pipe with writing instructions, then reset mid-cycle.
        bus.WriteRegD = 4'd9;
        bus.MemtoRegD = 1;
        set_ctl(1, 1, 1, 0);
        repeat (4) tick();
        check("fill_RegWriteE", bus.RegWriteE, 1);
        check("fill_RegWriteM", bus.RegWriteM, 1);
        check("fill_RegWriteW", bus.RegWriteW, 1);
        check("fill_MemtoRegW", bus.MemtoRegW, 1);
        check("fill_ValidW", bus.ValidW, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_PCF", bus.PCF, RESET_PC);
        check("arst_Valid", {bus.ValidD, bus.ValidE, bus.ValidM, bus.ValidW}, 0);
        check("arst_RegWrite", {bus.RegWriteE, bus.RegWriteM, bus.RegWriteW}, 0);
        check("arst_WriteRegW", bus.WriteRegW, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_PCF", bus.PCF, 1);
        check("post_ValidD", bus.ValidD, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
Pipeline register bank that consumes the hazard unit's StallF/StallD/FlushE and produces the per-stage register IDs and control bits the hazard unit reads back (RsE, RtE, WriteRegE/M/W, RegWriteE/M/W, MemtoRegE/M).
It holds the PC, IF/ID, ID/EX, EX/MEM and MEM/WB control registers.
It also keeps saturating stall and branch-flush performance counters.
It sits between fetch/decode datapath and the hazard unit in the 5-stage core.

Parameters:
PC_W, 16, PC width in instruction words
REG_W, 4, register-ID width (matches the 4-bit register file)
RESET_PC, 0, PC value loaded at reset
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
StallF  in  1  1 = fetch advances, 0 = hold PC (inverted sense, as driven by the hazard unit)
StallD  in  1  1 = IF/ID advances, 0 = hold IF/ID (inverted sense)
FlushE  in  1  0 = insert bubble into ID/EX, 1 = load normally (inverted sense)
InstrF  in  32  instruction fetched at PCF
PCSrcD  in  1  branch taken, resolved in decode
PCBranchD  in  PC_W  branch target
RsD, RtD, WriteRegD  in  REG_W each  decode-stage register IDs
RegWriteD, MemtoRegD  in  1 each  decode-stage control
CntClr  in  1  synchronous clear of both counters
PCF  out  PC_W  current fetch PC
InstrD  out  32  IF/ID instruction
PCPlus1D  out  PC_W  IF/ID PC+1
ValidD, ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
RsE, RtE, WriteRegE  out  REG_W each  ID/EX fields
RegWriteE, MemtoRegE  out  1 each  ID/EX control
WriteRegM  out  REG_W  EX/MEM destination
RegWriteM, MemtoRegM  out  1 each  EX/MEM control
WriteRegW  out  REG_W  MEM/WB destination
RegWriteW, MemtoRegW  out  1 each  MEM/WB control
StallCnt  out  CNT_W  cycles with StallD=0
FlushCnt  out  CNT_W  taken branches that cleared IF/ID

Behaviour:
- Reset (async, rst_n=0) forces the following, held until the first clk edge after release:
  - PCF=RESET_PC.
  - InstrD=0 (NOP), PCPlus1D=0.
  - All Valid*, RegWrite*, MemtoReg* = 0.
  - All register-ID outputs = 0.
  - Both counters = 0.
- PC, on each clk edge:
  - StallF=1: PCF <= PCSrcD ? PCBranchD : PCF+1, wrapping mod 2^PC_W.
  - StallF=0: hold.
- IF/ID:
  - StallD=0: hold everything. Hold wins over PCSrcD.
  - StallD=1 and PCSrcD=1: clear (InstrD=0, ValidD=0, PCPlus1D=0).
  - Otherwise: InstrD<=InstrF, PCPlus1D<=PCF+1, ValidD<=1.
- ID/EX:
  - FlushE=0: bubble. All fields 0, ValidE=0, so WriteRegE=0 and RegWriteE=0; a bubble is never a forwarding source.
  - FlushE=1: load RsD, RtD, WriteRegD, RegWriteD, MemtoRegD and ValidD.
  - RegWriteD and MemtoRegD are ANDed with ValidD so a cleared IF/ID never writes.
- EX/MEM and MEM/WB: always advance; there is no stall or flush downstream of E.
- Latency: a fields set loaded into ID/EX appears at M one cycle later and at W two cycles later.
- StallCnt: +1 on each cycle with StallD=0.
- FlushCnt: +1 on each cycle with StallD=1 and PCSrcD=1.
- Counter rules:
  - Both counters saturate at all-ones; no wrap.
  - CntClr has priority over increment: the next value is 0 even if an increment condition holds.
- Simultaneous events:
  - StallF=0 with StallD=1 is legal; each register obeys its own enable.
  - FlushE=0 while StallD=1 bubbles E and still advances D.
- Reset mid-operation: all stages are invalidated immediately (async); no partial state survives.

Decomposition:
- pipe_pkg holds:
  - REG_W.
  - NOP_INSTR (32'h0).
  - typedef ctrl_t {rs, rt, wreg, regwrite, memtoreg, valid}.
  - BUBBLE constant of type ctrl_t (all zero).
- Sub-module pipe_stage_reg: parameterised width, en, clr (synchronous), async rst_n to a reset value. It is instantiated for IF/ID, ID/EX, EX/MEM and MEM/WB.
- The PC and the counters stay in the top level.

Test Plan:
- Reset, then 3 cycles with StallF=StallD=FlushE=1 and PCSrcD=0 -> PCF = 0,1,2,3; ValidD=1 from cycle 1.
- Load WriteRegD=5, RegWriteD=1, FlushE=1 -> WriteRegE=5, then WriteRegM=5 next cycle, then WriteRegW=5 with RegWriteW=1 the cycle after.
- Load-use: hold StallF=StallD=FlushE=0 for 1 cycle -> PCF and InstrD unchanged; RegWriteE=0, WriteRegE=0; StallCnt=1.
- PCSrcD=1, PCBranchD=0x40, StallF=StallD=1 -> PCF=0x40, InstrD=0, ValidD=0, FlushCnt=1. Repeat with StallD=0 -> IF/ID held, FlushCnt unchanged.
- Force StallCnt to 0xFFFE and hold StallD=0 for 3 cycles -> StallCnt saturates at 0xFFFF. Then CntClr=1 together with StallD=0 -> StallCnt=0.
- Assert rst_n=0 mid-stream, between clock edges -> all Valid* and RegWrite* drop immediately, PCF=RESET_PC without waiting for a clk edge.
